// File: rtl/adder_tree_sched.sv
// adder_tree_sched: round-robin scheduler sharing a 2-stage 2a+b+2c+d adder tree among four requesters.
module adder_tree (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_c,
    input  logic [3:0] i_d,
    output logic [7:0] o_result
);
    logic [5:0] r_ab;
    logic [5:0] r_cd;
    logic [7:0] r_res;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ab  <= '0;
            r_cd  <= '0;
            r_res <= '0;
        end else begin
            r_ab  <= {1'b0, i_a, 1'b0} + {2'b0, i_b};
            r_cd  <= {1'b0, i_c, 1'b0} + {2'b0, i_d};
            r_res <= {2'b0, r_ab} + {2'b0, r_cd};
        end
    end
    assign o_result = r_res;
endmodule

module adder_tree_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_en,
    input  logic [3:0]       i_req,
    input  logic [63:0]      i_data,
    output logic [3:0]       o_gnt,
    output logic             o_rsp_valid,
    output logic [1:0]       o_rsp_id,
    output logic [7:0]       o_rsp_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_issue_cnt
);
    logic [1:0]       r_ptr;
    logic             r_v1;
    logic             r_v2;
    logic [1:0]       r_id1;
    logic [1:0]       r_id2;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_req;
    logic [3:0]       w_gnt;
    logic [1:0]       w_id;
    logic [1:0]       w_idx;
    logic             w_hs;
    logic [15:0]      w_op;

    assign w_req = i_req & {4{i_en & ~clr}};

    // Walk the search order backwards so the nearest requester to r_ptr wins.
    always_comb begin
        w_gnt = '0;
        w_id  = '0;
        w_idx = r_ptr;
        for (int j = 3; j >= 0; j--) begin
            w_idx = r_ptr + 2'(j);
            if (w_req[w_idx]) begin
                w_gnt = 4'b0001 << w_idx;
                w_id  = w_idx;
            end
        end
    end

    assign w_hs = |w_gnt;
    assign w_op = w_hs ? i_data[{w_id, 4'b0000} +: 16] : '0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ptr <= '0;
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_id1 <= '0;
            r_id2 <= '0;
            r_cnt <= '0;
        end else begin
            r_v1 <= w_hs;
            r_v2 <= r_v1;
            if (w_hs) begin
                r_ptr <= w_id + 2'd1;
                r_id1 <= w_id;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_v1)
                r_id2 <= r_id1;
        end
    end

    adder_tree u_tree (
        .clk      (clk),
        .clr      (clr),
        .i_a      (w_op[15:12]),
        .i_b      (w_op[11:8]),
        .i_c      (w_op[7:4]),
        .i_d      (w_op[3:0]),
        .o_result (o_rsp_data)
    );

    assign o_gnt       = w_gnt;
    assign o_rsp_valid = r_v2;
    assign o_rsp_id    = r_id2;
    assign o_busy      = r_v1 | r_v2;
    assign o_issue_cnt = r_cnt;
endmodule

// File: doc/adder_tree_sched.md
# adder_tree_sched

Round-robin scheduler that shares one `adder_tree` weighted-sum datapath among four requesters. The datapath computes 2a+b+2c+d on 4-bit operands. The block sits between up to four producer blocks and a single `adder_tree` instance, which it instantiates internally. It issues at most one operation per cycle, tracks each in-flight operation's owner through the datapath pipeline, and returns every result tagged with its requester ID.

## Interface
Parameters:
- `CNT_W`, 16, width of the issued-operation counter.

Ports:
- `clk`  in  1  clock
- `clr`  in  1  reset, asynchronous, active-high
- `i_en`  in  1  issue enable; 0 blocks new grants, in-flight ops still drain
- `i_req`  in  4  per-requester request, level, held until granted
- `i_data`  in  64  requester k operands at bits [16k+15:16k]: a=[15:12], b=[11:8], c=[7:4], d=[3:0]
- `o_gnt`  out  4  one-hot grant, combinational; handshake fires when `i_req[k] & o_gnt[k]`
- `o_rsp_valid`  out  1  result valid, one-cycle pulse per op
- `o_rsp_id`  out  2  requester ID of the current result
- `o_rsp_data`  out  8  result = 2a+b+2c+d (max 0x5A)
- `o_busy`  out  1  at least one op in flight
- `o_issue_cnt`  out  CNT_W  count of issued ops, wraps modulo 2^CNT_W

## Operation
- Round-robin pointer `rr_ptr` (2 bits, reset 0) marks the highest-priority requester. The search order is rr_ptr, rr_ptr+1, ... mod 4.
- `o_gnt` = one-hot of the first k in search order with `i_req[k]=1`, gated by `i_en` and `~clr`. It is 0 when no requests are pending.
- On a handshake to requester k:
  - `rr_ptr` <= k+1 mod 4.
  - `o_issue_cnt` increments.
  - The tag {valid=1, id=k} enters stage 1.
- No handshake: `rr_ptr` unchanged; the tag stage 1 valid is 0.
- Operand mux: the `adder_tree` i_a..i_d inputs are driven combinationally from the granted requester's nibbles. With no grant they are driven 0.
- Tag pipeline: stage 1 -> stage 2 every cycle, unconditionally. The datapath never stalls and results are not back-pressured.
  - `o_rsp_valid` = stage 2 valid.
  - `o_rsp_id` = stage 2 id.
  - `o_rsp_data` = `adder_tree` o_result.
- `o_rsp_id` holds its last value when `o_rsp_valid`=0. Consumers ignore `o_rsp_id` and `o_rsp_data` when not valid.
- `o_busy` = stage 1 valid | stage 2 valid.
- Requesters must hold `i_data` stable while `i_req` is high and not granted. `i_data` is sampled only in the handshake cycle.
- Dropping `i_req` before a grant withdraws the request with no side effects.

## Timing
- Reset (async, clr=1): `rr_ptr`=0, tag stages invalid, `o_rsp_valid`=0, `o_rsp_id`=0, `o_issue_cnt`=0, `o_busy`=0. `adder_tree` is also reset via `clr`, so `o_rsp_data`=0x00. `o_gnt`=0 while clr=1.
- Latency: a handshake in cycle N gives `o_rsp_valid`=1 with its data in cycle N+2. Throughput is 1 op/cycle sustained.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,... Any requester waits at most 3 cycles while `i_en`=1.
- `i_en` falling: the grant in that cycle is suppressed. Results of ops issued in N-1 and N-2 still appear.
- `i_en` rising: the grant is available the same cycle, with priority from the current `rr_ptr`.
- `clr` mid-operation: all in-flight ops are discarded, no response is produced for them, and the pointer returns to 0.
- Counter wrap: 0xFFFF + 1 -> 0x0000 at CNT_W=16. No flag is raised.
- Stage 1 and stage 2 update on every clk edge. A new issue and a retiring result in the same cycle are normal.

## Test plan
- Single op: requester 2, a=3 b=2 c=1 d=4, i_req[2] asserted cycle 0 -> o_gnt=0100 cycle 0; cycle 2 o_rsp_valid=1, o_rsp_id=2, o_rsp_data=0x0E; o_issue_cnt=1.
- Max operands: requester 0, all nibbles 0xF -> o_rsp_data=0x5A two cycles later.
- Full contention: i_req=1111 held 8 cycles, distinct data per requester -> grants 0,1,2,3,0,1,2,3; 8 back-to-back responses with matching ids and sums; o_busy high throughout.
- Pointer skip: rr_ptr=1, i_req=1001 -> grant requester 3, then requester 0 next cycle.
- i_en gating: i_req=1111, i_en=0 for 3 cycles mid-stream -> no grants, 2 pending results still emerge, o_busy falls, issue resumes from saved rr_ptr.
- Reset mid-flight: issue in cycles 0 and 1, assert clr in cycle 2 -> o_rsp_valid stays 0, o_issue_cnt=0, next grant after clr release goes to requester 0.
